inst_fetch: RTL and testbench

//   Instruction fetch unit: producer side of the decoder's inst/data inputs.

---
 rtl/inst_fetch.sv | 106 ++++++++++
 tb/tb_inst_fetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: walks a PC over a byte-wide program memory, assembles
// {opcode, lo} plus an optional operand byte, and hands them to execute.
module inst_fetch #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       inst,
  output logic [7:0]        data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in
);

  localparam logic [2:0] START      = 3'd0;
  localparam logic [2:0] FETCH_HI   = 3'd1;
  localparam logic [2:0] FETCH_LO   = 3'd2;
  localparam logic [2:0] FETCH_DATA = 3'd3;
  localparam logic [2:0] PRESENT    = 3'd4;

  localparam logic [ADDR_W-1:0] OFS_HI   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFS_LO   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFS_DATA = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] LEN_2    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] LEN_3    = ADDR_W'(3);

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] addr_ofs;
  logic              has_data;
  logic              data_src;

  // The opcode byte already sits in inst[15:8] when the lo byte arrives.
  assign data_src = inst[15] && (inst[10:9] == 2'b01);

  always_comb begin
    addr_ofs = OFS_HI;
    mem_req  = 1'b0;
    case (state)
      FETCH_HI:   begin addr_ofs = OFS_HI;   mem_req = 1'b1; end
      FETCH_LO:   begin addr_ofs = OFS_LO;   mem_req = 1'b1; end
      FETCH_DATA: begin addr_ofs = OFS_DATA; mem_req = 1'b1; end
      default:    begin addr_ofs = OFS_HI;   mem_req = 1'b0; end
    endcase
  end

  assign mem_addr   = pc + addr_ofs;
  assign inst_valid = (state == PRESENT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= START;
      pc       <= '0;
      inst     <= '0;
      data     <= '0;
      inst_pc  <= '0;
      has_data <= 1'b0;
    end else begin
      case (state)
        START: state <= FETCH_HI;
        FETCH_HI: begin
          if (mem_ack) begin
            inst[15:8] <= mem_rdata;
            state      <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (mem_ack) begin
            inst[7:0] <= mem_rdata;
            if (data_src) begin
              has_data <= 1'b1;
              state    <= FETCH_DATA;
            end else begin
              has_data <= 1'b0;
              data     <= 8'h00;
              inst_pc  <= pc;
              state    <= PRESENT;
            end
          end
        end
        FETCH_DATA: begin
          if (mem_ack) begin
            data    <= mem_rdata;
            inst_pc <= pc;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          // Redirects only take effect at the handoff edge.
          if (inst_ready) begin
            pc    <= pc_load ? pc_in : pc + (has_data ? LEN_3 : LEN_2);
            state <= FETCH_HI;
          end
        end
        default: state <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a byte memory model with programmable ack
// stalls, and one task per scenario checking outputs on the falling edge.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] inst;
  logic [7:0]  data;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        pc_load = 1'b0;
  logic [7:0]  pc_in = 8'h00;

  logic [7:0]  mem [256];
  logic        ack_en = 1'b1;
  int          stall_n = 0;
  int          wait_cnt = 0;
  int          cap_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  inst_fetch #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst(inst), .data(data), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .pc_load(pc_load), .pc_in(pc_in)
  );

  always #5 clk = ~clk;

  // Memory acks after stall_n waiting cycles on each request.
  assign mem_ack   = ack_en && (wait_cnt >= stall_n);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (!rst && mem_req && mem_ack) cap_cnt <= cap_cnt + 1;
    if (!rst && inst_valid && inst_ready)
      $display("handoff pc=%h inst=%h data=%h", inst_pc, inst, data);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if ({mem_req, inst_valid} !== 2'b00) begin n_err++;
      $display("FAIL reset req/valid: got %b want 00", {mem_req, inst_valid}); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_err++;
      $display("FAIL reset mem_addr: got %h want 00", mem_addr); end
    n_cmp++; if ({inst, data, inst_pc} !== 32'h0) begin n_err++;
      $display("FAIL reset inst/data/pc: got %h want 00000000", {inst, data, inst_pc}); end
  endtask

  task automatic test_two_byte();
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'h2A;
    inst_ready = 1'b1; pc_load = 1'b0;
    do_reset();
    step();
    n_cmp++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 8'h00, 1'b0}) begin n_err++;
      $display("FAIL two_byte hi req/addr/valid: got %h want %h", {mem_req, mem_addr, inst_valid}, {1'b1, 8'h00, 1'b0}); end
    step();
    n_cmp++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 8'h01, 1'b0}) begin n_err++;
      $display("FAIL two_byte lo req/addr/valid: got %h want %h", {mem_req, mem_addr, inst_valid}, {1'b1, 8'h01, 1'b0}); end
    step();
    n_cmp++; if ({inst_valid, mem_req} !== 2'b10) begin n_err++;
      $display("FAIL two_byte valid/req: got %b want 10", {inst_valid, mem_req}); end
    n_cmp++; if ({inst, data, inst_pc} !== {16'h002A, 8'h00, 8'h00}) begin n_err++;
      $display("FAIL two_byte inst/data/pc: got %h want 002a0000", {inst, data, inst_pc}); end
    step();
    n_cmp++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 8'h02, 1'b0}) begin n_err++;
      $display("FAIL two_byte next req/addr/valid: got %h want %h", {mem_req, mem_addr, inst_valid}, {1'b1, 8'h02, 1'b0}); end
    inst_ready = 1'b0;
  endtask

  task automatic test_data_src();
    clear_mem();
    mem[0] = 8'h82; mem[1] = 8'h11; mem[2] = 8'h5C;
    inst_ready = 1'b1; pc_load = 1'b0;
    do_reset();
    step();
    step();
    step();
    n_cmp++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 8'h02, 1'b0}) begin n_err++;
      $display("FAIL data_src operand req/addr/valid: got %h want %h", {mem_req, mem_addr, inst_valid}, {1'b1, 8'h02, 1'b0}); end
    step();
    n_cmp++; if ({inst_valid, inst, data, inst_pc} !== {1'b1, 16'h8211, 8'h5C, 8'h00}) begin n_err++;
      $display("FAIL data_src present: got %h want %h", {inst_valid, inst, data, inst_pc}, {1'b1, 16'h8211, 8'h5C, 8'h00}); end
    step();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h03}) begin n_err++;
      $display("FAIL data_src next hi req/addr: got %h want %h", {mem_req, mem_addr}, {1'b1, 8'h03}); end
    inst_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0] exp_addr [6];
    int base;
    exp_addr = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01};
    clear_mem();
    mem[0] = 8'h80; mem[1] = 8'h11;
    inst_ready = 1'b0; pc_load = 1'b0; stall_n = 2;
    do_reset();
    base = cap_cnt;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, exp_addr[i], 1'b0}) begin n_err++;
        $display("FAIL stall cycle %0d req/addr/valid: got %h want %h", i, {mem_req, mem_addr, inst_valid}, {1'b1, exp_addr[i], 1'b0}); end
    end
    step();
    n_cmp++; if ({inst_valid, inst, data} !== {1'b1, 16'h8011, 8'h00}) begin n_err++;
      $display("FAIL stall present: got %h want %h", {inst_valid, inst, data}, {1'b1, 16'h8011, 8'h00}); end
    n_cmp++; if (cap_cnt - base !== 2) begin n_err++;
      $display("FAIL stall captures: got %0d want 2", cap_cnt - base); end
    stall_n = 0;
  endtask

  task automatic test_hold();
    clear_mem();
    mem[0] = 8'h82; mem[1] = 8'h11; mem[2] = 8'h5C;
    inst_ready = 1'b0; pc_load = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    pc_load = 1'b1; pc_in = 8'h40;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if ({inst_valid, mem_req, inst, data, inst_pc} !== {2'b10, 16'h8211, 8'h5C, 8'h00}) begin n_err++;
        $display("FAIL hold cycle %0d: got %h want %h", i, {inst_valid, mem_req, inst, data, inst_pc}, {2'b10, 16'h8211, 8'h5C, 8'h00}); end
    end
    inst_ready = 1'b1;
    step();
    n_cmp++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 8'h40, 1'b0}) begin n_err++;
      $display("FAIL hold redirect req/addr/valid: got %h want %h", {mem_req, mem_addr, inst_valid}, {1'b1, 8'h40, 1'b0}); end
    inst_ready = 1'b0; pc_in = 8'h80;
    step();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h41}) begin n_err++;
      $display("FAIL hold load-during-fetch req/addr: got %h want %h", {mem_req, mem_addr}, {1'b1, 8'h41}); end
    pc_load = 1'b0;
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[8'h00] = 8'h5C; mem[8'hFE] = 8'h82; mem[8'hFF] = 8'h11;
    inst_ready = 1'b0; pc_load = 1'b1; pc_in = 8'hFE;
    do_reset();
    step(); step(); step();
    n_cmp++; if ({inst_valid, inst} !== {1'b1, 16'h5C00}) begin n_err++;
      $display("FAIL wrap first inst: got %h want %h", {inst_valid, inst}, {1'b1, 16'h5C00}); end
    inst_ready = 1'b1;
    step();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'hFE}) begin n_err++;
      $display("FAIL wrap redirect hi: got %h want %h", {mem_req, mem_addr}, {1'b1, 8'hFE}); end
    inst_ready = 1'b0; pc_load = 1'b0;
    step();
    n_cmp++; if (mem_addr !== 8'hFF) begin n_err++;
      $display("FAIL wrap lo addr: got %h want ff", mem_addr); end
    step();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin n_err++;
      $display("FAIL wrap operand addr: got %h want %h", {mem_req, mem_addr}, {1'b1, 8'h00}); end
    step();
    n_cmp++; if ({inst_valid, inst, data, inst_pc} !== {1'b1, 16'h8211, 8'h5C, 8'hFE}) begin n_err++;
      $display("FAIL wrap 3-byte present: got %h want %h", {inst_valid, inst, data, inst_pc}, {1'b1, 16'h8211, 8'h5C, 8'hFE}); end
    inst_ready = 1'b1;
    step();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h01}) begin n_err++;
      $display("FAIL wrap 3-byte next hi: got %h want %h", {mem_req, mem_addr}, {1'b1, 8'h01}); end
    inst_ready = 1'b0;
    mem[8'hFE] = 8'h12; mem[8'hFF] = 8'h34;
    step();
    step();
    n_cmp++; if ({inst_valid, inst, data, inst_pc} !== {1'b1, 16'h0000, 8'h00, 8'h01}) begin n_err++;
      $display("FAIL wrap inst at 01: got %h want %h", {inst_valid, inst, data, inst_pc}, {1'b1, 16'h0000, 8'h00, 8'h01}); end
    inst_ready = 1'b1; pc_load = 1'b1; pc_in = 8'hFE;
    step();
    inst_ready = 1'b0; pc_load = 1'b0;
    step();
    step();
    n_cmp++; if ({inst_valid, inst, data, inst_pc} !== {1'b1, 16'h1234, 8'h00, 8'hFE}) begin n_err++;
      $display("FAIL wrap 2-byte present: got %h want %h", {inst_valid, inst, data, inst_pc}, {1'b1, 16'h1234, 8'h00, 8'hFE}); end
    inst_ready = 1'b1;
    step();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin n_err++;
      $display("FAIL wrap 2-byte next hi: got %h want %h", {mem_req, mem_addr}, {1'b1, 8'h00}); end
    inst_ready = 1'b0;
  endtask

  task automatic test_rst_mid();
    clear_mem();
    mem[0] = 8'h82; mem[1] = 8'h11;
    inst_ready = 1'b0; pc_load = 1'b0;
    do_reset();
    step();
    step();
    n_cmp++; if ({mem_req, mem_addr, mem_ack} !== {1'b1, 8'h01, 1'b1}) begin n_err++;
      $display("FAIL rst_mid in lo: got %h want %h", {mem_req, mem_addr, mem_ack}, {1'b1, 8'h01, 1'b1}); end
    rst = 1'b1;
    step();
    n_cmp++; if ({mem_req, inst_valid, mem_addr, inst} !== {2'b00, 8'h00, 16'h0000}) begin n_err++;
      $display("FAIL rst_mid abort: got %h want %h", {mem_req, inst_valid, mem_addr, inst}, {2'b00, 8'h00, 16'h0000}); end
    rst = 1'b0;
    step();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin n_err++;
      $display("FAIL rst_mid restart: got %h want %h", {mem_req, mem_addr}, {1'b1, 8'h00}); end
    step();
    step();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h02}) begin n_err++;
      $display("FAIL rst_mid operand: got %h want %h", {mem_req, mem_addr}, {1'b1, 8'h02}); end
  endtask

  initial begin
    test_reset();
    test_two_byte();
    test_data_src();
    test_stall();
    test_hold();
    test_wrap();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
